// File: rtl/prim_resp_misr_if.sv
// Handshake and result bundle between the test controller, the primitive chain
// output and the response compactor.
interface prim_resp_misr_if #(
   parameter int W  = 4,
   parameter int CW = 3
);
   logic          start;
   logic          vec_valid;
   logic          vec_ready;
   logic [W-1:0]  resp;
   logic [W-1:0]  expected;
   logic          busy;
   logic          done;
   logic          pass;
   logic [W-1:0]  signature;
   logic [CW-1:0] vec_count;

   modport master (
      output start, vec_valid, resp, expected,
      input  vec_ready, busy, done, pass, signature, vec_count
   );

   modport slave (
      input  start, vec_valid, resp, expected,
      output vec_ready, busy, done, pass, signature, vec_count
   );
endinterface

// File: rtl/prim_resp_misr.sv
// Response compactor: paces vectors, waits a settle interval, folds the chain
// output into a MISR and compares the final signature against a golden value.
module prim_resp_misr #(
   parameter int IO_PAIRS    = 2,
   parameter int SETTLE      = 4,
   parameter int NUM_VECTORS = 4
) (
   input  logic             clk,
   input  logic             rst,
   prim_resp_misr_if.slave  bus
);
   localparam int W   = 2 * IO_PAIRS;
   localparam int CW  = $clog2(NUM_VECTORS + 1);
   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [CW-1:0]  LAST_IDX    = CW'(NUM_VECTORS - 1);
   localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   sig_q, sig_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [SCW-1:0] settle_q, settle_d;
   logic           pass_q, pass_d;
   logic           vec_ready_q, vec_ready_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [W-1:0]   sig_next;

   // Shift left with the end-around XOR of the two outer bits, then fold in data.
   function automatic logic [W-1:0] misr_step(input logic [W-1:0] sig,
                                              input logic [W-1:0] din);
      return {sig[W-2:0], sig[W-1] ^ sig[0]} ^ din;
   endfunction

   always_comb begin
      state_d  = state_q;
      sig_d    = sig_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      pass_d   = pass_q;
      sig_next = misr_step(sig_q, bus.resp);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d = ST_WAIT;
               sig_d   = '0;
               cnt_d   = '0;
               pass_d  = 1'b0;
            end
         end
         ST_WAIT: begin
            if (bus.vec_valid) begin
               settle_d = SETTLE_LOAD;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_q != '0) begin
               settle_d = settle_q - SCW'(1);
            end else begin
               sig_d = sig_next;
               cnt_d = cnt_q + CW'(1);
               // expected is only looked at on this final-sample edge
               if (cnt_q == LAST_IDX) begin
                  state_d = ST_DONE;
                  pass_d  = (sig_next == bus.expected);
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Status outputs are registered copies of the next state.
      vec_ready_d = (state_d == ST_WAIT);
      busy_d      = (state_d == ST_WAIT) || (state_d == ST_SETTLE);
      done_d      = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sig_q       <= '0;
         cnt_q       <= '0;
         settle_q    <= '0;
         pass_q      <= 1'b0;
         vec_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sig_q       <= sig_d;
         cnt_q       <= cnt_d;
         settle_q    <= settle_d;
         pass_q      <= pass_d;
         vec_ready_q <= vec_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.vec_ready = vec_ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.signature = sig_q;
   assign bus.vec_count = cnt_q;
endmodule

// File: tb/tb_prim_resp_misr.sv
// Directed-plus-random bench for prim_resp_misr against an arithmetic MISR model.
module tb_prim_resp_misr;
   localparam int IO_PAIRS    = 2;
   localparam int SETTLE      = 4;
   localparam int NUM_VECTORS = 4;
   localparam int W           = 2 * IO_PAIRS;
   localparam int CW          = $clog2(NUM_VECTORS + 1);
   localparam int LIMIT       = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [W-1:0] msig;
   int           mcnt;
   logic [W-1:0] exp_run;

   prim_resp_misr_if #(.W(W), .CW(CW)) bus ();

   prim_resp_misr #(
      .IO_PAIRS   (IO_PAIRS),
      .SETTLE     (SETTLE),
      .NUM_VECTORS(NUM_VECTORS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference rule in arithmetic form: double modulo 2^W, add parity of the
   // outer bits as the new LSB, then bitwise add the response.
   function automatic logic [W-1:0] mstep(input logic [W-1:0] s, input logic [W-1:0] r);
      logic [W-1:0] dbl;
      int           fb;
      dbl = W'((int'(s) * 2) % (1 << W));
      fb  = ((int'(s) >> (W - 1)) + int'(s)) % 2;
      return (dbl + W'(fb)) ^ r;
   endfunction

   function automatic logic [W-1:0] junk();
      return W'($urandom);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_sig"}, 32'(bus.signature), 32'(msig));
      check({tag, "_cnt"}, 32'(bus.vec_count), mcnt);
   endtask

   task automatic start_run();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      msig = '0;
      mcnt = 0;
      check("start_ready", 32'(bus.vec_ready), 1);
      check("start_done", 32'(bus.done), 0);
      check("start_pass", 32'(bus.pass), 0);
      check_model("start");
   endtask

   // One vector: resp is junk except around edges t+SETTLE-1 and t+SETTLE.
   task automatic do_vector(input logic [W-1:0] r, input bit poke);
      int n;
      n = 0;
      while (bus.vec_ready !== 1'b1 && n < LIMIT) begin
         tick();
         n++;
      end
      check("ready_timeout", 32'(n < LIMIT), 1);
      if (poke) begin
         bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         check_model("poke_wait");
         check("poke_wait_ready", 32'(bus.vec_ready), 1);
      end
      bus.vec_valid = 1'b1;
      bus.resp      = junk();
      tick();
      check("hs_ready_low", 32'(bus.vec_ready), 0);
      check("hs_busy", 32'(bus.busy), 1);
      for (int k = 1; k <= SETTLE - 2; k++) begin
         bus.resp      = junk();
         bus.vec_valid = 1'($urandom);
         bus.start     = poke && (k == 1);
         tick();
         bus.start = 1'b0;
         check("settle_ready_low", 32'(bus.vec_ready), 0);
         check_model("settle");
      end
      bus.resp      = r;
      bus.vec_valid = 1'($urandom);
      tick();
      check("pre_ready_low", 32'(bus.vec_ready), 0);
      bus.expected = (mcnt == NUM_VECTORS - 1) ? exp_run : junk();
      tick();
      bus.vec_valid = 1'b0;
      bus.resp      = junk();
      bus.expected  = junk();
      msig = mstep(msig, r);
      mcnt++;
      check_model("sample");
      if (mcnt == NUM_VECTORS) begin
         check("final_done", 32'(bus.done), 1);
         check("final_pass", 32'(bus.pass), 32'(msig == exp_run));
         check("final_ready", 32'(bus.vec_ready), 0);
         check("final_busy", 32'(bus.busy), 0);
      end else begin
         check("mid_ready", 32'(bus.vec_ready), 1);
         check("mid_done", 32'(bus.done), 0);
      end
   endtask

   initial begin
      logic [W-1:0] hseq [4];
      logic [W-1:0] rv [NUM_VECTORS];
      logic [W-1:0] fsig;
      logic [W-1:0] rc;
      int           ecnt;

      bus.start     = 1'b0;
      bus.vec_valid = 1'b0;
      bus.resp      = '0;
      bus.expected  = '0;

      // Reset state
      tick();
      tick();
      check("rst_ready", 32'(bus.vec_ready), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_pass", 32'(bus.pass), 0);
      check("rst_sig", 32'(bus.signature), 0);
      check("rst_cnt", 32'(bus.vec_count), 0);
      rst = 1'b0;
      tick();
      check("idle_ready", 32'(bus.vec_ready), 0);

      // Constant 0xF stream, matching golden
      hseq[0] = 4'hF; hseq[1] = 4'h1; hseq[2] = 4'hC; hseq[3] = 4'h6;
      exp_run = 4'h6;
      start_run();
      for (int v = 0; v < NUM_VECTORS; v++) begin
         do_vector(4'hF, 1'b0);
         check("known_sig", 32'(bus.signature), 32'(hseq[v]));
      end
      check("known_pass", 32'(bus.pass), 1);
      check("known_cnt", 32'(bus.vec_count), 4);

      // DONE holds its results
      tick();
      tick();
      check("hold_done", 32'(bus.done), 1);
      check("hold_sig", 32'(bus.signature), 32'h6);

      // Same stream, wrong golden
      exp_run = 4'h7;
      start_run();
      for (int v = 0; v < NUM_VECTORS; v++) do_vector(4'hF, v == 1);
      check("wrong_done", 32'(bus.done), 1);
      check("wrong_pass", 32'(bus.pass), 0);
      check("wrong_sig", 32'(bus.signature), 32'h6);

      // Back-to-back run with zero responses
      exp_run = 4'h0;
      start_run();
      for (int v = 0; v < NUM_VECTORS; v++) do_vector(4'h0, 1'b0);
      check("zero_sig", 32'(bus.signature), 0);
      check("zero_pass", 32'(bus.pass), 1);

      // Random runs, golden right about half the time
      for (int run = 0; run < 4; run++) begin
         fsig = '0;
         for (int v = 0; v < NUM_VECTORS; v++) begin
            rv[v] = junk();
            fsig  = mstep(fsig, rv[v]);
         end
         exp_run = ($urandom_range(0, 1) == 1) ? fsig : (fsig ^ W'($urandom_range(1, (1 << W) - 1)));
         start_run();
         for (int v = 0; v < NUM_VECTORS; v++) do_vector(rv[v], 1'($urandom));
         check("rand_sig", 32'(bus.signature), 32'(fsig));
      end

      // vec_valid held high: one vector every SETTLE+1 cycles
      rc = junk();
      fsig = '0;
      for (int v = 0; v < NUM_VECTORS; v++) fsig = mstep(fsig, rc);
      exp_run      = fsig;
      bus.expected = fsig;
      start_run();
      bus.resp      = rc;
      bus.vec_valid = 1'b1;
      for (int i = 1; i <= NUM_VECTORS * (SETTLE + 1); i++) begin
         tick();
         ecnt = i / (SETTLE + 1);
         if (ecnt > mcnt) begin
            msig = mstep(msig, rc);
            mcnt = ecnt;
         end
         check_model("stream");
      end
      bus.vec_valid = 1'b0;
      check("stream_done", 32'(bus.done), 1);
      check("stream_pass", 32'(bus.pass), 1);

      // Asynchronous reset in the middle of a settle interval
      exp_run = junk();
      start_run();
      do_vector(W'($urandom_range(1, (1 << W) - 1)), 1'b0);
      check("pre_rst_sig_nz", 32'(bus.signature != '0), 1);
      bus.vec_valid = 1'b1;
      tick();
      bus.vec_valid = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_ready", 32'(bus.vec_ready), 0);
      check("arst_busy", 32'(bus.busy), 0);
      check("arst_done", 32'(bus.done), 0);
      check("arst_pass", 32'(bus.pass), 0);
      check("arst_sig", 32'(bus.signature), 0);
      check("arst_cnt", 32'(bus.vec_count), 0);
      #2;
      rst = 1'b0;
      tick();
      check("post_rst_ready", 32'(bus.vec_ready), 0);
      start_run();
      do_vector(4'h5, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/prim_resp_misr.md
# prim_resp_misr

Downstream response compactor for the parallel XOR/NOT primitive chain used in simulator performance evaluation. It paces stimulus application, waits a fixed settle interval for the chain output to propagate, then folds the `2*IO_PAIRS`-bit chain output into a multiple-input signature register (MISR). After a programmed number of vectors it compares the final signature against a golden value and reports pass or fail. It sits between the chain's `out` bus and the test controller.

## Interface
- `IO_PAIRS`, default 2: number of primitive pairs. Data width is `W = 2*IO_PAIRS`; `IO_PAIRS >= 1`.
- `SETTLE`, default 4: cycles from vector handshake to response sample; `SETTLE >= 1`.
- `NUM_VECTORS`, default 4: vectors compacted per run; `NUM_VECTORS >= 1`.
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: begin a run. Accepted only in `IDLE` or `DONE`.
- `vec_valid`, in, 1: upstream has applied a new vector to the chain input.
- `vec_ready`, out, 1: block accepts a vector handshake.
- `resp`, in, W: chain output bus (`out` of the primitive chain).
- `expected`, in, W: golden signature. Sampled when the run completes.
- `busy`, out, 1: high in `WAIT_VEC` and `SETTLE`.
- `done`, out, 1: high in `DONE`.
- `pass`, out, 1: registered compare result. Meaningful when `done` is high.
- `signature`, out, W: current MISR contents.
- `vec_count`, out, `$clog2(NUM_VECTORS+1)`: number of vectors compacted so far in this run.

## Operation
- The FSM has four states: `IDLE`, `WAIT_VEC`, `SETTLE`, `DONE`.
- **IDLE**
  - `vec_ready=0`.
  - On `start`: `signature` is cleared to 0, `vec_count` to 0, `pass` to 0; go to `WAIT_VEC`.
- **WAIT_VEC**
  - `vec_ready=1`. `vec_ready` is a Moore output: it depends on state only.
  - On `vec_valid`: load settle counter with `SETTLE-1`; go to `SETTLE`.
- **SETTLE**
  - `vec_valid` is ignored.
  - If the counter is nonzero, decrement it.
  - If the counter is 0, sample `resp` into the MISR and increment `vec_count`.
    - If the new count equals `NUM_VECTORS`: go to `DONE` and register `pass = (next_signature == expected)`.
    - Otherwise go to `WAIT_VEC`.
- **DONE**
  - Holds `signature`, `vec_count` and `pass`.
  - `start` restarts the run with the same clearing as in `IDLE`.
- MISR update: `fb = sig[W-1] ^ sig[0]`; `sig_next = {sig[W-2:0], fb} ^ resp`. Arithmetic is modulo-2 on width W with no carries.
- `start` asserted in `WAIT_VEC` or `SETTLE` is ignored.
- `expected` is only sampled on the final-sample edge; it may change at any other time.

## Timing
- Reset values: state `IDLE`, `vec_ready=0`, `busy=0`, `done=0`, `pass=0`, `signature=0`, `vec_count=0`, settle counter 0.
- Handshake on edge t samples `resp` on edge t+SETTLE. `resp` must be stable from edge t+SETTLE-1 through edge t+SETTLE.
- Minimum per-vector period is SETTLE+1 cycles. A run from the `start` edge to `done` high takes at least 1 + NUM_VECTORS*(SETTLE+1) cycles.
- `done` and `pass` assert in the same cycle, the one following the final sample edge.
- `start` edge in `DONE`: `done` drops and `vec_ready` rises in the following cycle.
- `rst` mid-run: all outputs return to reset values immediately, asynchronously, with no partial signature retained. After `rst` deasserts, the first `start` edge is honoured.
- `vec_count` never exceeds `NUM_VECTORS`. The settle counter does not wrap.

## Test plan
- Reset check: assert `rst` mid-`SETTLE` with `signature` nonzero -> all outputs read 0 and state is `IDLE` before the next clock edge; `vec_ready=0`.
- Defaults, `resp` held at 4'hF for 4 vectors, `expected=4'h6` -> intermediate signatures 4'hF, 4'h1, 4'hC, 4'h6; `done=1`, `pass=1`, `vec_count=4`.
- Same stimulus with `expected=4'h7` -> `done=1`, `pass=0`, `signature=4'h6`.
- Settle timing: `resp=4'h0` until edge t+3, then 4'hF from edge t+3 through t+4 after the first handshake at edge t -> first sampled value is 4'hF, so `signature=4'hF` after edge t+4. `vec_ready` is low for edges t+1 through t+4.
- Protocol abuse:
  - `vec_valid` held high continuously -> exactly one vector every SETTLE+1 cycles.
  - `start` pulsed while `busy` -> no effect on `vec_count` or `signature`.
- Back-to-back runs: `start` in `DONE` with `resp=4'h0` for 4 vectors -> `signature` cleared and ends at 4'h0; `pass=1` with `expected=4'h0`.
